// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot / periodic modes, a one-cycle
// terminal-count pulse and a saturating expiry counter.
module down_counter_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic [3:0]       tc_cnt
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [3:0]       tc_cnt_q, tc_cnt_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    tc_cnt_d = tc_cnt_q;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      tc_cnt_d = 4'd0;
      state_d  = (load_val != '0) ? StRun : StIdle;
    end else if (state_q == StRun && en) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        // Expiry; count==0 cannot occur in RUN but is treated the same way.
        tc_d = 1'b1;
        if (tc_cnt_q != 4'd15) begin
          tc_cnt_d = tc_cnt_q + 4'd1;
        end
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      tc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      tc_cnt_q <= tc_cnt_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign busy   = (state_q == StRun);
  assign tc_cnt = tc_cnt_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed testbench for down_counter_timer with hand-computed expectations.
module tb_down_counter_timer;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic [3:0]       tc_cnt;

  int checks;
  int failures;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .tc_cnt      (tc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; load_val = 8'd7; en = 1'b1; auto_reload = 1'b0;
    tick();
    checks++;
    if (count !== 8'd0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (busy !== 1'b0 || tc !== 1'b0 || tc_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b tc=%b tc_cnt=%0d want 0 0 0", busy, tc, tc_cnt);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || count !== 8'd0) begin
      failures++; $display("FAIL reset_idle_after: busy=%b count=%0d want 0 0", busy, count);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_cnt [4];
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
    load = 1'b1; load_val = 8'd3; en = 1'b1; auto_reload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      checks++;
      if (count !== exp_cnt[i] || tc !== (i == 3)) begin
        failures++;
        $display("FAIL one_shot_step%0d: count=%0d tc=%b want %0d %b",
                 i, count, tc, exp_cnt[i], (i == 3));
      end
    end
    checks++;
    if (busy !== 1'b0 || tc_cnt !== 4'd1) begin
      failures++; $display("FAIL one_shot_end: busy=%b tc_cnt=%0d want 0 1", busy, tc_cnt);
    end
    tick();
    checks++;
    if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL one_shot_hold: count=%0d tc=%b busy=%b want 0 0 0", count, tc, busy);
    end
  endtask

  task automatic test_periodic();
    load = 1'b1; load_val = 8'd2; en = 1'b1; auto_reload = 1'b1;
    for (int i = 0; i < 7; i++) begin
      logic [7:0] want;
      want = (i % 2 == 0) ? 8'd2 : 8'd1;
      tick();
      load = 1'b0;
      checks++;
      if (count !== want || tc !== (i > 0 && want == 8'd2) || busy !== 1'b1) begin
        failures++;
        $display("FAIL periodic_step%0d: count=%0d tc=%b busy=%b want %0d %b 1",
                 i, count, tc, busy, want, (i > 0 && want == 8'd2));
      end
    end
    checks++;
    if (tc_cnt !== 4'd3) begin
      failures++; $display("FAIL periodic_tc_cnt: got %0d want 3", tc_cnt);
    end
  endtask

  task automatic test_gating();
    logic [7:0] exp_cnt [6];
    logic       en_seq  [6];
    exp_cnt = '{8'd5, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
    en_seq  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    load = 1'b1; load_val = 8'd5; auto_reload = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = en_seq[i];
      tick();
      load = 1'b0;
      checks++;
      if (count !== exp_cnt[i] || tc !== 1'b0) begin
        failures++;
        $display("FAIL gating_step%0d: count=%0d tc=%b want %0d 0", i, count, tc, exp_cnt[i]);
      end
    end
    // Load on what would be the expiry edge must win.
    load = 1'b1; load_val = 8'd9; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    checks++;
    if (count !== 8'd9 || tc !== 1'b0 || tc_cnt !== 4'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_priority: count=%0d tc=%b tc_cnt=%0d busy=%b want 9 0 0 1",
               count, tc, tc_cnt, busy);
    end
  endtask

  task automatic test_zero_load();
    int bad;
    load = 1'b1; load_val = 8'd0; en = 1'b0;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL zero_load: count=%0d busy=%b tc=%b want 0 0 0", count, busy, tc);
    end
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) bad++;
    end
    en = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL idle_ignores_en: bad_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_reset_mid_run();
    load = 1'b1; load_val = 8'd200; en = 1'b1; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    repeat (50) tick();
    checks++;
    if (count !== 8'd150 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_run_count: count=%0d busy=%b want 150 1", count, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_reset: count=%0d busy=%b tc=%b want 0 0 0", count, busy, tc);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (count !== 8'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: count=%0d busy=%b want 0 0", count, busy);
    end
    load = 1'b1; load_val = 8'd3;
    tick();
    load = 1'b0;
    tick();
    tick();
    checks++;
    if (count !== 8'd1) begin
      failures++; $display("FAIL pre_expiry_count: got %0d want 1", count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tc !== 1'b0 || count !== 8'd0 || busy !== 1'b0 || tc_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_at_expiry: tc=%b count=%0d busy=%b tc_cnt=%0d want 0 0 0 0",
               tc, count, busy, tc_cnt);
    end
    tick();
    checks++;
    if (tc !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_at_expiry_after: tc=%b busy=%b want 0 0", tc, busy);
    end
    en = 1'b0;
  endtask

  task automatic test_saturation();
    load = 1'b1; load_val = 8'd1; en = 1'b1; auto_reload = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 8'd1 || tc !== 1'b0 || tc_cnt !== 4'd0) begin
      failures++;
      $display("FAIL sat_load: count=%0d tc=%b tc_cnt=%0d want 1 0 0", count, tc, tc_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      logic [3:0] want;
      want = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      tick();
      checks++;
      if (tc !== 1'b1 || count !== 8'd1 || tc_cnt !== want || busy !== 1'b1) begin
        failures++;
        $display("FAIL sat_step%0d: tc=%b count=%0d tc_cnt=%0d busy=%b want 1 1 %0d 1",
                 i, tc, count, tc_cnt, busy, want);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (tc !== 1'b0 || tc_cnt !== 4'd15) begin
      failures++; $display("FAIL sat_hold: tc=%b tc_cnt=%0d want 0 15", tc, tc_cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_gating();
    test_zero_load();
    test_reset_mid_run();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port load, input, 1; a load request, sampled each posedge.
REQ-005 The block SHALL have port load_val, input, WIDTH; the start/reload value, sampled when load=1.
REQ-006 The block SHALL have port en, input, 1; a decrement enable, effective only in RUN.
REQ-007 The block SHALL have port auto_reload, input, 1; 1 selects periodic mode and 0 selects one-shot, sampled at the expiry edge.
REQ-008 The block SHALL have port count, output, WIDTH; the registered current count.
REQ-009 The block SHALL have port tc, output, 1; a registered terminal-count pulse, one cycle wide.
REQ-010 The block SHALL have port busy, output, 1; it is 1 exactly while the FSM is in RUN.
REQ-011 The block SHALL have port tc_cnt, output, 4; a saturating count of expiries since the last load or reset.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and RUN, plus a WIDTH-bit reload register holding the last loaded value.
REQ-013 On load=1 in either state, the block SHALL set count<=load_val, reload<=load_val and tc_cnt<=0.
REQ-014 On that same load, next state SHALL be RUN if load_val!=0, otherwise IDLE; tc SHALL stay 0.
REQ-015 Load SHALL take priority over decrement and expiry in the same cycle, so no tc pulse occurs on a load cycle.
REQ-016 In RUN with en=1 and count>1, the block SHALL set count<=count-1 with no tc pulse.
REQ-017 In RUN with en=0, count, state and tc_cnt SHALL hold, and tc SHALL be 0 the next cycle.
REQ-018 In RUN with en=1 and count==1 (expiry), the block SHALL assert tc=1 for the following cycle only and set tc_cnt<=min(tc_cnt+1,15).
REQ-019 At expiry with auto_reload=1, the block SHALL set count<=reload and stay in RUN; the period is reload cycles of en=1.
REQ-020 At expiry with auto_reload=0, the block SHALL set count<=0 and go to IDLE.
REQ-021 In IDLE, count SHALL hold and en SHALL be ignored; count never wraps below 0 and never wraps above reload.
REQ-022 The tc output SHALL be 0 on every cycle except the one immediately following an expiry edge.
REQ-023 The tc_cnt output SHALL saturate at 15 and never wrap to 0 except on load or reset.
REQ-024 The busy output SHALL be decoded from the registered state, with no combinational path from any input.

Reset
REQ-025 While rst=1 at posedge clk, the block SHALL set count=0, reload=0, tc=0, tc_cnt=0 and state=IDLE (busy=0).
REQ-026 rst SHALL override load, en and any in-progress count, including the expiry cycle; no tc pulse follows a reset.
REQ-027 After rst deasserts, the block SHALL stay in IDLE until a load with a nonzero load_val.

Verification
REQ-028 One-shot: WIDTH=8, load 3, auto_reload=0, en=1 held -> count 3,2,1,0; tc=1 for exactly one cycle, coinciding with count=0; then busy=0, tc_cnt=1, count holds at 0.
REQ-029 Periodic: load 2, auto_reload=1, en=1 for 7 cycles -> count 2,1,2,1,2,1,2; tc pulses three times, each in a cycle where count shows 2; tc_cnt=3; busy stays 1.
REQ-030 Gating and load priority: load 5, en toggles 1,0,1 -> count 5,4,4,3; at count=1 assert load=1 with load_val=9 and en=1 -> count=9, tc=0, tc_cnt=0.
REQ-031 Zero load and IDLE: load 0 -> count=0, busy=0, no tc; en=1 for 10 cycles -> count stays 0, no tc.
REQ-032 Reset mid-run and at expiry: load 200 and run 50 cycles, then rst -> count=0, busy=0, tc=0 next cycle; repeat with rst asserted on the count==1 edge -> no tc pulse.
REQ-033 Saturation: load 1 with auto_reload=1, en=1 for 20 cycles -> tc high every cycle (back-to-back pulses), count stays 1, tc_cnt reaches 15 and holds at 15.
